// File: rtl/pe_dual_mode.sv
// Dual-mode systolic processing element: weight-stationary MAC with double-buffered
// weights, or output-stationary accumulator with a shift-out drain chain.
module pe_dual_mode #(
    parameter int unsigned ACT_WIDTH   = 8,
    parameter int unsigned WGT_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter bit          SIGNED_MODE = 1'b1,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic                 valid_in,
    input  logic [ACT_WIDTH-1:0] a_in,
    input  logic [WGT_WIDTH-1:0] w_in,
    input  logic                 w_load,
    input  logic                 w_swap,
    input  logic [ACC_WIDTH-1:0] psum_in,
    input  logic                 psum_valid_in,
    input  logic                 drain,
    input  logic                 clear,
    output logic [ACT_WIDTH-1:0] a_out,
    output logic                 a_valid_out,
    output logic [WGT_WIDTH-1:0] w_out,
    output logic [ACC_WIDTH-1:0] psum_out,
    output logic                 psum_valid_out,
    output logic                 sat_flag,
    output logic                 collision
);

    localparam int unsigned PROD_WIDTH = ACT_WIDTH + WGT_WIDTH;
    localparam int unsigned MSB        = ACC_WIDTH - 1;
    localparam logic [1:0]  ModeWs     = 2'b00;
    localparam logic [1:0]  ModeOs     = 2'b01;
    localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Full-precision product, extended to accumulator width.
    function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [ACT_WIDTH-1:0] a,
                                                     input logic [WGT_WIDTH-1:0] w);
        logic signed [PROD_WIDTH-1:0] as;
        logic signed [PROD_WIDTH-1:0] ws;
        logic        [PROD_WIDTH-1:0] p;
        if (SIGNED_MODE) begin
            as = PROD_WIDTH'($signed(a));
            ws = PROD_WIDTH'($signed(w));
            p  = as * ws;
            return ACC_WIDTH'($signed(p));
        end else begin
            p = PROD_WIDTH'(a) * PROD_WIDTH'(w);
            return ACC_WIDTH'(p);
        end
    endfunction

    logic [ACT_WIDTH-1:0] a_out_q, a_out_d;
    logic                 a_valid_q, a_valid_d;
    logic [WGT_WIDTH-1:0] w_out_q, w_out_d;
    logic [WGT_WIDTH-1:0] shadow_q, shadow_d;
    logic [WGT_WIDTH-1:0] active_q, active_d;
    logic [ACC_WIDTH-1:0] psum_q, psum_d;
    logic                 psum_valid_q, psum_valid_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic                 coll_q, coll_d;

    logic [ACC_WIDTH-1:0] base, prod, sum, sat_val, add_res;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [WGT_WIDTH-1:0] wgt;
    logic                 ovf, ovf_used;

    // Shared multiplier/adder: WS adds to psum_in, OS adds to the local accumulator.
    always_comb begin
        base    = (mode == ModeOs) ? acc_q : psum_in;
        wgt     = (mode == ModeOs) ? w_in : active_q;
        prod    = mul_ext(a_in, wgt);
        sum_ext = {1'b0, base} + {1'b0, prod};
        sum     = sum_ext[ACC_WIDTH-1:0];
        if (SIGNED_MODE) begin
            ovf     = (base[MSB] == prod[MSB]) && (sum[MSB] != base[MSB]);
            sat_val = base[MSB] ? AccMin : AccMax;
        end else begin
            ovf     = sum_ext[ACC_WIDTH];
            sat_val = '1;
        end
        add_res = (ovf && SATURATE) ? sat_val : sum;
    end

    always_comb begin
        a_out_d      = a_out_q;
        a_valid_d    = 1'b0;
        w_out_d      = w_out_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        psum_d       = psum_q;
        psum_valid_d = 1'b0;
        acc_d        = acc_q;
        coll_d       = 1'b0;
        ovf_used     = 1'b0;

        case (mode)
            ModeWs: begin
                a_valid_d = valid_in;
                if (valid_in) a_out_d = a_in;
                if (w_load) begin
                    shadow_d = w_in;
                    w_out_d  = w_in;
                end
                if (w_swap) active_d = shadow_q;
                if (valid_in) begin
                    psum_d       = add_res;
                    psum_valid_d = 1'b1;
                    ovf_used     = ovf;
                end
            end
            ModeOs: begin
                a_valid_d = valid_in;
                if (valid_in) begin
                    a_out_d = a_in;
                    w_out_d = w_in;
                end
                if (drain) begin
                    // Own result wins the chain slot; an incoming psum is dropped.
                    psum_d       = acc_q;
                    psum_valid_d = 1'b1;
                    coll_d       = psum_valid_in;
                    acc_d        = valid_in ? prod : '0;
                end else begin
                    if (valid_in) begin
                        acc_d    = add_res;
                        ovf_used = ovf;
                    end
                    if (psum_valid_in) begin
                        psum_d       = psum_in;
                        psum_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        sat_d = sat_q | ovf_used;
        if (clear) begin
            acc_d = '0;
            sat_d = 1'b0;
            if (mode == ModeOs && drain) begin
                psum_d       = psum_q;
                psum_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out_q      <= '0;
            a_valid_q    <= 1'b0;
            w_out_q      <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            coll_q       <= 1'b0;
        end else begin
            a_out_q      <= a_out_d;
            a_valid_q    <= a_valid_d;
            w_out_q      <= w_out_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            coll_q       <= coll_d;
        end
    end

    assign a_out          = a_out_q;
    assign a_valid_out    = a_valid_q;
    assign w_out          = w_out_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_valid_q;
    assign sat_flag       = sat_q;
    assign collision      = coll_q;

endmodule

// File: tb/tb_pe_dual_mode.sv
// Directed bench for pe_dual_mode: signed 32-bit, unsigned 32-bit and signed 16-bit
// instances share one stimulus stream; each vector has a hand-computed expectation.
module tb_pe_dual_mode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        valid_in = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  w_in = '0;
    logic        w_load = 1'b0;
    logic        w_swap = 1'b0;
    logic [31:0] psum_in = '0;
    logic        psum_valid_in = 1'b0;
    logic        drain = 1'b0;
    logic        clear = 1'b0;

    logic [7:0]  s_a_out, u_a_out, h_a_out;
    logic        s_a_valid, u_a_valid, h_a_valid;
    logic [7:0]  s_w_out, u_w_out, h_w_out;
    logic [31:0] s_psum, u_psum;
    logic [15:0] h_psum;
    logic        s_pv, u_pv, h_pv;
    logic        s_sat, u_sat, h_sat;
    logic        s_coll, u_coll, h_coll;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_dual_mode u_s32 (
        .clk(clk), .reset(reset), .mode(mode), .valid_in(valid_in), .a_in(a_in), .w_in(w_in),
        .w_load(w_load), .w_swap(w_swap), .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .drain(drain), .clear(clear), .a_out(s_a_out), .a_valid_out(s_a_valid),
        .w_out(s_w_out), .psum_out(s_psum), .psum_valid_out(s_pv), .sat_flag(s_sat),
        .collision(s_coll)
    );

    pe_dual_mode #(.SIGNED_MODE(1'b0)) u_u32 (
        .clk(clk), .reset(reset), .mode(mode), .valid_in(valid_in), .a_in(a_in), .w_in(w_in),
        .w_load(w_load), .w_swap(w_swap), .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .drain(drain), .clear(clear), .a_out(u_a_out), .a_valid_out(u_a_valid),
        .w_out(u_w_out), .psum_out(u_psum), .psum_valid_out(u_pv), .sat_flag(u_sat),
        .collision(u_coll)
    );

    pe_dual_mode #(.ACC_WIDTH(16)) u_s16 (
        .clk(clk), .reset(reset), .mode(mode), .valid_in(valid_in), .a_in(a_in), .w_in(w_in),
        .w_load(w_load), .w_swap(w_swap), .psum_in(psum_in[15:0]),
        .psum_valid_in(psum_valid_in), .drain(drain), .clear(clear), .a_out(h_a_out),
        .a_valid_out(h_a_valid), .w_out(h_w_out), .psum_out(h_psum), .psum_valid_out(h_pv),
        .sat_flag(h_sat), .collision(h_coll)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in = 1'b0; w_load = 1'b0; w_swap = 1'b0; psum_valid_in = 1'b0;
        drain = 1'b0; clear = 1'b0;
    endtask

    task automatic os_mac(input logic [7:0] a, input logic [7:0] w, input int n);
        mode = 2'b01; valid_in = 1'b1; a_in = a; w_in = w;
        for (int i = 0; i < n; i++) tick();
        valid_in = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b1;
        #10;
        check("rst_a_out", s_a_out, 0);
        check("rst_a_valid", s_a_valid, 0);
        check("rst_w_out", s_w_out, 0);
        check("rst_psum", s_psum, 0);
        check("rst_pv", s_pv, 0);
        check("rst_sat", s_sat, 0);
        check("rst_coll", s_coll, 0);
        @(negedge clk);
        reset = 1'b0;

        // WS signed: -3 * 5 + 100
        mode = 2'b00; w_load = 1'b1; w_in = 8'hFD; tick();
        check("ws_w_out", s_w_out, 8'hFD);
        w_load = 1'b0; w_swap = 1'b1; tick();
        w_swap = 1'b0; valid_in = 1'b1; a_in = 8'd5; psum_in = 32'd100; tick();
        check("ws_psum", s_psum, 85);
        check("ws_pv", s_pv, 1);
        check("ws_a_out", s_a_out, 5);
        check("ws_a_valid", s_a_valid, 1);
        check("ws_psum_unsigned", u_psum, 1365);
        valid_in = 1'b0; tick();
        check("ws_idle_pv", s_pv, 0);
        check("ws_idle_hold", s_psum, 85);
        check("ws_idle_a_valid", s_a_valid, 0);
        check("ws_idle_a_hold", s_a_out, 5);

        // Double buffer
        w_load = 1'b1; w_in = 8'd2; tick();
        w_load = 1'b0; w_swap = 1'b1; tick();
        w_load = 1'b1; w_in = 8'd7; w_swap = 1'b1; valid_in = 1'b1; a_in = 8'd1;
        psum_in = 32'd0; tick();
        check("db_same_cycle", s_psum, 2);
        check("db_w_out", s_w_out, 7);
        w_load = 1'b0; w_swap = 1'b0; tick();
        check("db_after_both", s_psum, 2);
        valid_in = 1'b0; w_swap = 1'b1; tick();
        w_swap = 1'b0; valid_in = 1'b1; tick();
        check("db_after_swap", s_psum, 7);
        idle();

        // OS unsigned-range accumulate and drain
        mode = 2'b01; clear = 1'b1; tick(); clear = 1'b0;
        os_mac(8'd10, 8'd10, 4);
        check("os_w_out", s_w_out, 10);
        drain = 1'b1; tick();
        check("os_drain", s_psum, 400);
        check("os_drain_u", u_psum, 400);
        check("os_drain_pv", s_pv, 1);
        check("os_drain_coll", s_coll, 0);
        drain = 1'b0; os_mac(8'd3, 8'd4, 1);
        check("os_acc_pv", s_pv, 0);
        drain = 1'b1; psum_valid_in = 1'b1; psum_in = 32'd999; tick();
        check("coll_psum", s_psum, 12);
        check("coll_pulse", s_coll, 1);
        check("coll_pv", s_pv, 1);
        drain = 1'b0; psum_in = 32'd555; tick();
        check("chain_psum", s_psum, 555);
        check("chain_pv", s_pv, 1);
        check("coll_drop", s_coll, 0);
        psum_valid_in = 1'b0; drain = 1'b1; tick();
        check("acc_cleared", s_psum, 0);
        drain = 1'b0; os_mac(8'd2, 8'd3, 1);
        drain = 1'b1; valid_in = 1'b1; a_in = 8'd5; w_in = 8'd5; tick();
        check("drain_mac_old", s_psum, 6);
        valid_in = 1'b0; tick();
        check("drain_mac_new", s_psum, 25);
        drain = 1'b0; os_mac(8'd200, 8'd200, 1);
        drain = 1'b1; tick();
        check("os_unsigned", u_psum, 40000);
        check("os_signed", s_psum, 3136);
        drain = 1'b0; os_mac(8'd1, 8'd1, 1);
        drain = 1'b1; clear = 1'b1; tick();
        check("clear_drain_pv", s_pv, 0);
        clear = 1'b0; tick();
        check("clear_drain_acc", s_psum, 0);
        check("clear_drain_pv2", s_pv, 1);
        idle();

        // Mode change keeps weights; reserved mode is inert
        mode = 2'b00; valid_in = 1'b1; a_in = 8'd1; psum_in = 32'd0; tick();
        check("mode_keep_w", s_psum, 7);
        mode = 2'b10; a_in = 8'd9; w_in = 8'd9; tick();
        check("rsv_a_valid", s_a_valid, 0);
        check("rsv_a_hold", s_a_out, 1);
        check("rsv_pv", s_pv, 0);
        valid_in = 1'b0; mode = 2'b01; drain = 1'b1; tick();
        check("rsv_no_acc", s_psum, 0);
        idle();

        // Saturation on the 16-bit instance
        clear = 1'b1; tick(); clear = 1'b0;
        os_mac(8'd127, 8'd127, 2);
        os_mac(8'd26, 8'd17, 1);
        check("sat_pre", h_sat, 0);
        os_mac(8'd127, 8'd127, 1);
        check("sat_set", h_sat, 1);
        check("sat_wide", s_sat, 0);
        os_mac(8'd127, 8'd127, 1);
        drain = 1'b1; tick(); drain = 1'b0;
        check("sat_max", h_psum, 16'h7FFF);
        check("sat_wide_val", s_psum, 64958);
        check("sat_sticky", h_sat, 1);
        os_mac(8'd1, 8'd1, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        check("sat_clear", h_sat, 0);
        drain = 1'b1; tick(); drain = 1'b0;
        check("clear_acc", h_psum, 0);
        os_mac(8'h80, 8'd127, 3);
        drain = 1'b1; tick(); drain = 1'b0;
        check("sat_min", h_psum, 16'h8000);
        check("neg_wide", s_psum, 32'hFFFF4180);
        check("neg_unsigned", u_psum, 48768);
        check("sat_min_flag", h_sat, 1);

        // Asynchronous reset mid-accumulation
        os_mac(8'd10, 8'd10, 3);
        #2 reset = 1'b1;
        #1;
        check("ar_psum", s_psum, 0);
        check("ar_a_out", s_a_out, 0);
        check("ar_w_out", s_w_out, 0);
        check("ar_sat", h_sat, 0);
        #2 reset = 1'b0;
        drain = 1'b1; tick(); drain = 1'b0;
        check("ar_drain", s_psum, 0);
        check("ar_drain_pv", s_pv, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
